load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum REQ-state cycles to wait for dmem_ack before aborting.
REQ-002 SHALL have ports: clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have: MemReadM  input  1  load in Memory stage; MemWriteM  input  1  store in Memory stage.
REQ-005 SHALL have: Funct3M  input  3  access size/sign; ALUResultM  input  32  byte address; WriteDataM  input  32  store data.
REQ-006 SHALL have: dmem_req  output  1; dmem_we  output  1; dmem_addr  output  32 (word-aligned); dmem_wdata  output  32; dmem_be  output  4.
REQ-007 SHALL have: dmem_ack  input  1  one-cycle completion pulse; dmem_rdata  input  32  read word, valid with ack.
REQ-008 SHALL have: ReadDataM  output  32  formatted load result; StallM  output  1  freeze upstream pipeline; BusErrM  output  1  timeout pulse; MisalignM  output  1  misalignment pulse.

Function
REQ-009 SHALL use FSM states IDLE, REQ, DONE.
REQ-010 IDLE: if MemReadM or MemWriteM, SHALL assert StallM combinationally and enter REQ on the next edge, registering address, data, byte enables and we.
REQ-011 REQ: SHALL hold dmem_req=1 and all dmem_* outputs stable, StallM=1, until dmem_ack.
REQ-012 On dmem_ack in REQ: SHALL register the formatted load result into ReadDataM (stores: ReadDataM unchanged) and enter DONE.
REQ-013 DONE: SHALL drive StallM=0 and dmem_req=0 for exactly one cycle, SHALL NOT start a new access, and SHALL return to IDLE; minimum access latency is therefore 3 cycles (IDLE, REQ, DONE) with a zero-wait ack.
REQ-014 Timeout: after TIMEOUT_CYCLES REQ cycles without ack, SHALL drop dmem_req, set ReadDataM=0, pulse BusErrM for one cycle, and enter DONE.
REQ-015 MemReadM and MemWriteM both set SHALL be treated as a store.
REQ-016 dmem_addr SHALL be {ALUResultM[31:2],2'b00}.
REQ-017 Stores: Funct3 000 SB, be=0001<<addr[1:0], byte replicated x4; 001 SH, be=0011<<(2*addr[1]), half replicated x2; 010 SW, be=1111.
REQ-018 Loads: 000 LB sign-extended; 001 LH sign-extended; 010 LW; 100 LBU zero-extended; 101 LHU zero-extended; lane selected by addr[1:0]; loads SHALL drive dmem_be=1111.
REQ-019 Undefined Funct3 values SHALL be treated as word access.
REQ-020 dmem_ack outside REQ SHALL be ignored.

Reset
REQ-021 reset low SHALL asynchronously force the FSM to IDLE and all registered outputs to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, ReadDataM, BusErrM, MisalignM, and the timeout counter.
REQ-022 Reset during REQ SHALL abandon the access with no retry after release.

Configuration
REQ-023 With MISALIGN_TRAP_EN defined, a misaligned access (half with addr[0]=1, word with addr[1:0]!=0) seen in IDLE SHALL NOT issue dmem_req, SHALL pulse MisalignM for one cycle, and SHALL go directly to DONE with ReadDataM=0.
REQ-024 Without MISALIGN_TRAP_EN, MisalignM SHALL be tied 0 and misaligned accesses SHALL proceed with the low address bits forced to natural alignment (half: addr[0]=0; word: addr[1:0]=0).

Verification
REQ-025 LB at 0x103 with rdata 0x80FF_FF7F and ack in the first REQ cycle -> be=1111, ReadDataM=0xFFFF_FF80, StallM high for 2 cycles.
REQ-026 SH of 0x1234_ABCD at 0x202 -> dmem_addr=0x200, be=1100, wdata=0xABCD_ABCD, dmem_we=1.
REQ-027 LW with no ack and TIMEOUT_CYCLES=4 -> dmem_req high exactly 4 cycles, then BusErrM one-cycle pulse and ReadDataM=0.
REQ-028 LW at 0x101: with MISALIGN_TRAP_EN -> no dmem_req and one MisalignM pulse; without -> dmem_addr=0x100 and normal load.
REQ-029 Reset driven low in the 2nd REQ cycle, then ack -> dmem_req=0 immediately, ack ignored, and the FSM stays in IDLE.
REQ-030 Back-to-back LW then SW -> second access enters REQ only after the DONE cycle with no duplicate request.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data-memory access with a 3-state FSM and an ack timeout.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of silently aligning them.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM,
    output logic        MisalignM
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_lane;
    logic             r_byte;
    logic             r_half;
    logic             r_unsigned;

    logic        w_access;
    logic        w_byte;
    logic        w_half;
    logic        w_trap;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    // Both strobes set means store; stores only know 000/001, loads add the unsigned 100/101.
    assign w_access = MemReadM | MemWriteM;
    assign w_byte   = (Funct3M == 3'b000) | (~MemWriteM & (Funct3M == 3'b100));
    assign w_half   = (Funct3M == 3'b001) | (~MemWriteM & (Funct3M == 3'b101));
    assign w_lane   = w_byte ? ALUResultM[1:0] : (w_half ? {ALUResultM[1], 1'b0} : 2'b00);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        if (MemWriteM && w_byte) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{WriteDataM[7:0]}};
        end else if (MemWriteM && w_half) begin
            w_be    = 4'b0011 << w_lane;
            w_wdata = {2{WriteDataM[15:0]}};
        end
    end

    assign w_shifted = dmem_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_load = w_shifted;
        if (r_byte)
            w_load = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
        else if (r_half)
            w_load = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
    end

    always_comb begin
        case (r_state)
            S_IDLE:  StallM = w_access;
            S_REQ:   StallM = 1'b1;
            default: StallM = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign;

    assign w_misalign = (w_half & ALUResultM[0]) | (~w_byte & ~w_half & (ALUResultM[1:0] != 2'b00));
    assign w_trap     = w_misalign;
    assign MisalignM  = r_misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_misalign <= 1'b0;
        else
            r_misalign <= (r_state == S_IDLE) & w_access & w_misalign;
    end
`else
    assign w_trap    = 1'b0;
    assign MisalignM = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lane     <= 2'b00;
            r_byte     <= 1'b0;
            r_half     <= 1'b0;
            r_unsigned <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            dmem_be    <= 4'b0000;
            ReadDataM  <= 32'h0;
            BusErrM    <= 1'b0;
        end else begin
            BusErrM <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access && w_trap) begin
                        ReadDataM <= 32'h0;
                        r_state   <= S_DONE;
                    end else if (w_access) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWriteM;
                        dmem_addr  <= {ALUResultM[31:2], 2'b00};
                        dmem_wdata <= w_wdata;
                        dmem_be    <= w_be;
                        r_lane     <= w_lane;
                        r_byte     <= w_byte;
                        r_half     <= w_half;
                        r_unsigned <= Funct3M[2];
                        r_cnt      <= '0;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A late ack in the final allowed cycle still wins over the timeout.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we)
                            ReadDataM <= w_load;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dmem_req  <= 1'b0;
                        ReadDataM <= 32'h0;
                        BusErrM   <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
